// File: rtl/controller_tc_pkg.sv
// Shared definitions for the test-controller status input port:
// Avalon register addresses and edge-capture encodings.
package controller_tc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/controller_tc_sync_edge.sv
// Multi-flop synchroniser for the asynchronous status bus, followed by a
// previous-sample register and the per-bit edge detector.
module controller_tc_sync_edge
  import controller_tc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // NOTE: every stage is reset, so reset also flushes in-flight samples and
  // prev starts at 0 (a bit held high through reset reports a rising edge).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make the chain shift one stage per
      // clock regardless of statement order.
      sync_q[0] <= in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: default first so no path through the case leaves edge_o unassigned.
    edge_o = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_o = sync_o & ~prev_q;
      EDGE_FALL: edge_o = ~sync_o & prev_q;
      EDGE_ANY:  edge_o = sync_o ^ prev_q;
      default:   edge_o = '0;
    endcase
  end

endmodule

// File: rtl/controller_tc_status_input.sv
// Avalon-MM input PIO for test-controller status flags: DATA, IRQMASK and
// sticky write-1-to-clear EDGECAP registers with a maskable level interrupt.
module controller_tc_status_input
  import controller_tc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0]  sync_w;
  logic [WIDTH-1:0]  edge_w;
  logic [WIDTH-1:0]  irqmask_q, irqmask_d;
  logic [WIDTH-1:0]  edgecap_q, edgecap_d;
  logic [WIDTH-1:0]  clear_w;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rd_en, wr_en;
  logic              unused_ok;

  controller_tc_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (in_port),
    .sync_o  (sync_w),
    .edge_o  (edge_w)
  );

  assign rd_en     = chipselect & write_n;
  assign wr_en     = chipselect & ~write_n;
  assign unused_ok = &{1'b0, writedata};

  always_comb begin
    irqmask_d  = irqmask_q;
    clear_w    = '0;
    readdata_d = readdata_q;

    if (wr_en) begin
      case (addr_e'(address))
        ADDR_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
        ADDR_EDGECAP: clear_w   = writedata[WIDTH-1:0];
        default:      ;
      endcase
    end

    // Set is OR-ed in after the clear so a coincident edge is never lost.
    edgecap_d = (edgecap_q & ~clear_w) | edge_w;

    if (rd_en) begin
      case (addr_e'(address))
        ADDR_DATA:    readdata_d = DATA_W'(sync_w);
        ADDR_DIR:     readdata_d = '0;
        ADDR_IRQMASK: readdata_d = DATA_W'(irqmask_q);
        ADDR_EDGECAP: readdata_d = DATA_W'(edgecap_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
